// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared widths, FSM state and digit bundle for the BCD arbiter slice
package bcd_pkg;

    localparam int BCD_IN_W  = 8;
    localparam int BCD_DIG_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } bcd_arb_state_t;

    typedef struct packed {
        logic [BCD_DIG_W-1:0] hundreds;
        logic [BCD_DIG_W-1:0] tens;
        logic [BCD_DIG_W-1:0] ones;
    } bcd3_t;

endpackage

// File: rtl/bcd.sv
// rtl/bcd.sv - combinational 8-bit binary to three-digit BCD converter (shift-and-add-3)
module bcd
    import bcd_pkg::*;
(
    input  logic [BCD_IN_W-1:0] bin,
    output bcd3_t               digits
);

    localparam int SH_W = 3 * BCD_DIG_W + BCD_IN_W;

    logic [SH_W-1:0] sh;

    always_comb begin
        sh = '0;
        sh[BCD_IN_W-1:0] = bin;
        for (int i = 0; i < BCD_IN_W; i++) begin
            if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
            if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
            if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
            sh = sh << 1;
        end
    end

    assign digits.hundreds = sh[19:16];
    assign digits.tens     = sh[15:12];
    assign digits.ones     = sh[11:8];

endmodule

// File: rtl/bcd_share_arb.sv
// rtl/bcd_share_arb.sv - round-robin sharing of one bcd converter between N_REQ requesters
module bcd_share_arb
    import bcd_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BCD_IN_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [BCD_IN_W-1:0]       rsp_bin,
    output logic [BCD_DIG_W-1:0]      rsp_hundreds,
    output logic [BCD_DIG_W-1:0]      rsp_tens,
    output logic [BCD_DIG_W-1:0]      rsp_ones,
    output logic                      busy
);

    bcd_arb_state_t        state_q, state_d;
    logic [ID_W-1:0]       rr_ptr;
    logic [BCD_IN_W-1:0]   op_q;
    logic [ID_W-1:0]       id_q;
    bcd3_t                 conv;
    bcd3_t                 rsp_dig_q;

    logic                  found;
    logic [ID_W-1:0]       win;
    logic [ID_W-1:0]       next_ptr;
    logic [BCD_IN_W-1:0]   sel_data;
    logic                  grant;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // First valid index at or after rr_ptr, scanning upward with wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[wrap_add(rr_ptr, k)]) begin
                found = 1'b1;
                win   = wrap_add(rr_ptr, k);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) sel_data = req_data[BCD_IN_W*i +: BCD_IN_W];
        end
    end

    assign next_ptr = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant     = 1'b1;
                    req_ready = N_REQ'(1) << win;
                    state_d   = CALC;
                end
            end
            CALC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The grant strobe must not leak out while reset is held.
        if (!rst_n) begin
            grant     = 1'b0;
            req_ready = '0;
        end
    end

    bcd u_bcd (
        .bin    (op_q),
        .digits (conv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            op_q      <= '0;
            id_q      <= '0;
            rsp_id    <= '0;
            rsp_bin   <= '0;
            rsp_dig_q <= '0;
        end else begin
            if (grant) begin
                op_q   <= sel_data;
                id_q   <= win;
                rr_ptr <= next_ptr;
            end
            if (state_q == CALC) begin
                rsp_id    <= id_q;
                rsp_bin   <= op_q;
                rsp_dig_q <= conv;
            end
        end
    end

    assign rsp_valid    = (state_q == RESP);
    assign busy         = (state_q != IDLE);
    assign rsp_hundreds = rsp_dig_q.hundreds;
    assign rsp_tens     = rsp_dig_q.tens;
    assign rsp_ones     = rsp_dig_q.ones;

endmodule

// File: doc/bcd_share_arb.md
# bcd_share_arb

Round-robin arbiter and sequencer that shares one combinational `bcd` converter (8-bit binary to hundreds/tens/ones BCD) between `N_REQ` requesters. Each request carries an 8-bit binary operand. The block accepts one request at a time, latches the operand, registers the converted digits, and presents them on a single valid/ready response port tagged with the requester index. It sits between the multiplier result consumers (display/readout paths) and the shared BCD datapath.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default 2: requester index width, equal to clog2(`N_REQ`).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  N_REQ: per-requester request valid.
- `req_data`  in  8*N_REQ: flattened operands; requester i uses bits [8i+7:8i].
- `req_ready`  out  N_REQ: per-requester accept strobe; at most one bit high (one-hot or zero).
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response consumer ready.
- `rsp_id`  out  ID_W: index of the requester that is being answered.
- `rsp_bin`  out  8: echoed binary operand.
- `rsp_hundreds`, `rsp_tens`, `rsp_ones`  out  4 each: BCD digits.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If any `req_valid` is high, the winner is the first valid index at or after `rr_ptr`, scanning upward with wrap.
  - `req_ready[winner]` is driven high combinationally in that cycle.
  - On the clock edge, `req_data` of the winner is latched into `op_q` and the winner index into `id_q`; `rr_ptr` becomes (winner+1) mod `N_REQ`; next state is CALC.
- CALC:
  - `op_q` drives the `bcd` instance.
  - On the edge, the digits, `op_q` and `id_q` are registered into the `rsp_*` registers and `rsp_valid` is set; next state is RESP.
- RESP:
  - `rsp_valid`=1. All `rsp_*` outputs hold stable until `rsp_valid && rsp_ready`.
  - On handshake, `rsp_valid` clears and the next state is IDLE. No new request is accepted in RESP.
- `req_ready` is 0 in CALC and RESP.
- Requesters hold `req_valid` and `req_data` stable until they see `req_ready`. A valid that drops before it is granted is simply not served.
- Arithmetic: hundreds is 0..2; tens and ones are 0..9; all digits are zero-extended to 4 bits. 255 converts to 2/5/5 and 0 converts to 0/0/0.
- `rr_ptr` is `ID_W` bits wide. With non-power-of-2 `N_REQ`, the wrap from `N_REQ`-1 goes to 0.
- Fairness: a continuously asserted requester is granted within `N_REQ` grants.

## Timing
- Reset (`rst_n` low, takes effect immediately):
  - state=IDLE, `rr_ptr`=0, `op_q`=0, `id_q`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_bin`=0, all digits 0.
  - `busy`=0, and `req_ready` is forced to 0 while `rst_n` is low.
- Latency: grant at edge T, `rsp_valid` high after edge T+1.
- Minimum initiation interval is 3 cycles (grant, CALC, RESP with `rsp_ready`=1). The next grant comes in the cycle after the response handshake.
- Reset asserted in CALC or RESP discards the in-flight request with no response. The requester has already seen its `req_ready` and does not re-request.
- Simultaneous valids are resolved only by `rr_ptr`. There are no priorities.
- `rsp_ready` held low keeps the FSM in RESP indefinitely. `busy` stays 1 and all `req_ready` stay 0.

## Structure
- Shared package `bcd_pkg`:
  - `BCD_IN_W`=8, `BCD_DIG_W`=4.
  - State enum `bcd_arb_state_t` {IDLE, CALC, RESP}.
  - Digit bundle typedef `bcd3_t` (hundreds, tens, ones).
- One sub-module: the existing `bcd` converter, instantiated once and unchanged, fed from `op_q`.
- Round-robin pick is a function or local always block, not a separate module.

## Test plan
- Single request on req 0 with `req_data`=8'hAA, `rsp_ready`=1 -> `req_ready`=4'b0001 for one cycle; `rsp_valid` two edges later with id 0, bin 8'hAA, digits 1/7/0.
- All four valid at once with operands 0x16, 0x46, 0xFF, 0x00 -> responses in id order 0,1,2,3 with digits 0/2/2, 0/7/0, 2/5/5, 0/0/0. `rr_ptr` ends at 0.
- Req 1 and req 3 continuously valid starting from `rr_ptr`=2 -> grants alternate 3,1,3,1. Req 1 is never starved.
- `rsp_ready` held low for 10 cycles in RESP with operand 0xE7 -> digits 2/3/1 stay stable, `busy`=1, `req_ready`=0 throughout. Releasing `rsp_ready` completes the handshake and returns to IDLE.
- `rst_n` pulsed low during CALC for operand 0x55 -> all outputs return to zero asynchronously and no response is produced. After release, a new request on req 2 with 0x0F gives digits 0/1/5, id 2.
- Random valid/ready traffic for 10k cycles -> `req_ready` is always at most one-hot, responses match a reference model, and no requester waits more than `N_REQ` grants.
